// File: rtl/uart_pkg.sv
// Shared UART definitions: default framing constants, receiver FSM state encoding
// and the 2-of-3 majority vote used by the receive path.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        UART_ST_IDLE   = 3'd0,
        UART_ST_START  = 3'd1,
        UART_ST_DATA   = 3'd2,
        UART_ST_PARITY = 3'd3,
        UART_ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic uart_majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-parser byte interface: the receiver drives through the master modport,
// the command parser observes through the slave modport.
interface uart_rx_if import uart_pkg::*; #(parameter int DATA_BITS = UART_DATA_BITS);

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (output data, valid, frame_err, parity_err, busy);
    modport slave  (input  data, valid, frame_err, parity_err, busy);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input that idles high; both stages
// reset to 1 so a reset never looks like a falling edge.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with mid-cell 2-of-3 voting and a 1-cycle valid strobe.
// Define UART_RX_PARITY_EN to add a parity cell between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line idle, waiting for a tick with rx_s low
// START  | validating the start bit; a high vote aborts as a false start
// DATA   | shifting in DATA_BITS payload bits, LSB first
// PARITY | voting the parity cell (UART_RX_PARITY_EN only)
// STOP   | voting the stop bit; result is published at the vote tick
module uart_rx import uart_pkg::*; #(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int PARITY_ODD = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        rxd,
    uart_rx_if.master   rx_bus
);

    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BI_W = $clog2(DATA_BITS);
    localparam int M    = OVERSAMPLE / 2;

    localparam logic [SC_W-1:0] SC_PRE  = SC_W'(M - 1);
    localparam logic [SC_W-1:0] SC_MID  = SC_W'(M);
    localparam logic [SC_W-1:0] SC_VOTE = SC_W'(M + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = UART_ST_IDLE;
    localparam logic [2:0] S_START  = UART_ST_START;
    localparam logic [2:0] S_DATA   = UART_ST_DATA;
    localparam logic [2:0] S_PARITY = UART_ST_PARITY;
    localparam logic [2:0] S_STOP   = UART_ST_STOP;

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx: DATA_BITS must be 5..9");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE > 32) begin : g_bad_oversample
        $error("uart_rx: OVERSAMPLE must be 8..32");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_rx: PARITY_ODD must be 0 or 1");
    end

    logic                 rx_s;
    logic [2:0]           state_q, state_d;
    logic [SC_W-1:0]      sc_q, sc_d;
    logic [BI_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 vote, vote_now, cell_end;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = PARITY_ODD[0];
    logic                 parity_bad_q, parity_bad_d;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rx_s)
    );

    // Samples at M-1 and M are held; the third is the live line on the vote tick.
    assign vote     = uart_majority3(samp_q[1], samp_q[0], rx_s);
    assign vote_now = (sc_q == SC_VOTE);
    assign cell_end = (sc_q == SC_LAST);

    always_comb begin
        state_d      = state_q;
        sc_d         = sc_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        samp_d       = samp_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
`endif
        if (tick) begin
            if (state_q == S_IDLE) begin
                if (!rx_s) begin
                    state_d = S_START;
                    sc_d    = SC_W'(1);
                end
            end else begin
                sc_d = cell_end ? '0 : sc_q + SC_W'(1);
                if (sc_q == SC_PRE) samp_d[1] = rx_s;
                if (sc_q == SC_MID) samp_d[0] = rx_s;
                case (state_q)
                    S_START: begin
                        if (vote_now && vote) begin
                            state_d = S_IDLE;
                            sc_d    = '0;
                        end else if (cell_end) begin
                            state_d   = S_DATA;
                            bit_idx_d = '0;
                        end
                    end
                    S_DATA: begin
                        if (vote_now) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                        if (cell_end) begin
                            if (bit_idx_q == BI_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_d = S_PARITY;
`else
                                state_d = S_STOP;
`endif
                            end else begin
                                bit_idx_d = bit_idx_q + BI_W'(1);
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (vote_now) parity_bad_d = (((^shift_q) ^ vote) != PAR_SENSE);
                        if (cell_end) state_d = S_STOP;
                    end
`endif
                    S_STOP: begin
                        // Publish at the vote so a start bit right after the stop bit is not missed.
                        if (vote_now) begin
                            data_d      = shift_q;
                            valid_d     = 1'b1;
                            frame_err_d = !vote;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = parity_bad_q;
`endif
                            state_d     = S_IDLE;
                            sc_d        = '0;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        sc_d    = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sc_q         <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            samp_q       <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sc_q         <= sc_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
`endif
        end
    end

    assign rx_bus.data       = data_q;
    assign rx_bus.valid      = valid_q;
    assign rx_bus.frame_err  = frame_err_q;
    assign rx_bus.parity_err = parity_err_q;
    assign rx_bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clk with OVERSAMPLE=16 (64 clk per bit cell).
// Parity steps are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    logic clk;
    logic reset;
    logic tick;
    logic rxd;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] q_data[$];
    logic       q_fe[$];
    logic       q_pe[$];
    logic       q_busy[$];

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(0)) dut (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .rxd    (rxd),
        .rx_bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int ph;
        ph   = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            ph   = (ph + 1) % 4;
            tick = (ph == 0);
        end
    end

    // Record every cycle valid is high; a stretched pulse shows up as an extra frame.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.valid) begin
                q_data.push_back(bus.data);
                q_fe.push_back(bus.frame_err);
                q_pe.push_back(bus.parity_err);
                q_busy.push_back(bus.busy);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clk(64);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) rxd = 1'b1;
`endif
        send_bit(stop);
        rxd = 1'b1;
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic fe, input logic pe);
        check({tag, "_count"}, q_data.size() != 0, 1);
        if (q_data.size() != 0) begin
            check({tag, "_data"},  q_data.pop_front(), d);
            check({tag, "_ferr"},  q_fe.pop_front(),   fe);
            check({tag, "_perr"},  q_pe.pop_front(),   pe);
            check({tag, "_busy"},  q_busy.pop_front(), 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        rxd   = 1'b1;
        wait_clk(4);
        check("rst_valid", bus.valid,      1'b0);
        check("rst_busy",  bus.busy,       1'b0);
        check("rst_data",  bus.data,       8'h00);
        check("rst_ferr",  bus.frame_err,  1'b0);
        check("rst_perr",  bus.parity_err, 1'b0);
        reset = 1'b0;
        wait_clk(16);

        // Plain frame
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_clk(64);
        expect_frame("a5", 8'hA5, 1'b0, 1'b0);
        check("a5_extra", q_data.size(), 0);
        check("a5_busy_after", bus.busy, 1'b0);

        // False start: low for 3 ticks only
        rxd = 1'b0;
        wait_clk(8);
        check("fs_busy_rise", bus.busy, 1'b1);
        wait_clk(4);
        rxd = 1'b1;
        wait_clk(48);
        check("fs_busy_fall", bus.busy, 1'b0);
        check("fs_no_valid", q_data.size(), 0);
        wait_clk(32);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_clk(64);
        expect_frame("3c", 8'h3C, 1'b0, 1'b0);

        // Stop bit driven low
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clk(128);
        expect_frame("3c_stop0", 8'h3C, 1'b1, 1'b0);
        check("3c_stop0_extra", q_data.size(), 0);

        // Reset in the middle of bit 4
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rxd = 1'b1;
        wait_clk(32);
        check("mid_busy_before", bus.busy, 1'b1);
        reset = 1'b1;
        wait_clk(1);
        check("mid_valid", bus.valid,      1'b0);
        check("mid_busy",  bus.busy,       1'b0);
        check("mid_data",  bus.data,       8'h00);
        check("mid_ferr",  bus.frame_err,  1'b0);
        check("mid_perr",  bus.parity_err, 1'b0);
        reset = 1'b0;
        wait_clk(200);
        check("mid_no_valid", q_data.size(), 0);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_clk(64);
        expect_frame("5a", 8'h5A, 1'b0, 1'b0);

        // One-tick glitch high in the middle of bit 2 of an all-zero payload
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rxd = 1'b0;
        wait_clk(32);
        rxd = 1'b1;
        wait_clk(4);
        rxd = 1'b0;
        wait_clk(28);
        for (int i = 3; i < 8; i++) send_bit(1'b0);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        send_bit(1'b1);
        wait_clk(64);
        expect_frame("glitch", 8'h00, 1'b0, 1'b0);

        // Back-to-back frames with no idle between stop and next start
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        wait_clk(64);
        check("b2b_count", q_data.size(), 2);
        expect_frame("b2b_11", 8'h11, 1'b0, 1'b0);
        expect_frame("b2b_22", 8'h22, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clk(64);
        expect_frame("par_ok", 8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clk(64);
        expect_frame("par_bad", 8'h07, 1'b0, 1'b1);
`endif

        check("final_extra", q_data.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive stage that consumes the 1-cycle `tick` pulse (BAUD×OVERSAMPLE rate) from the baud generator and turns the asynchronous `rxd` line into parallel bytes. It sits between the pin and the command parser of the motor-PID host link. The block synchronises the line, validates start bits and majority-votes each bit at mid-cell. It presents each byte with a one-cycle `valid` strobe and error flags.

## Interface
- `DATA_BITS`, 8: payload bits per frame, LSB first; legal range 5..9.
- `OVERSAMPLE`, 16: ticks per bit cell; must equal the baud generator's oversample; legal range 8..32.
- `PARITY_ODD`, 0: with the parity feature compiled in, 0 selects even parity and 1 selects odd.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `tick`  in  1  1-cycle strobe at BAUD×OVERSAMPLE.
- `rxd`  in  1  asynchronous serial line; idles high.
- `data`  out  DATA_BITS  last received payload; held until the next `valid`.
- `valid`  out  1  1-cycle pulse when a frame completes.
- `frame_err`  out  1  qualified by `valid`; high when the stop bit is voted 0.
- `parity_err`  out  1  qualified by `valid`; high on parity mismatch; constant 0 when the parity feature is compiled out.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- `rxd` passes through a 2-flop synchroniser, giving `rx_s`. Both flops reset to 1.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- The sample counter `sc` has width clog2(OVERSAMPLE) and advances only on `tick`. Let M = OVERSAMPLE/2.
- IDLE: on a `tick` with `rx_s`=0, go to START and set `sc`←1. The detecting tick counts as sample 0.
- In every non-IDLE state, each `tick` does `sc`←`sc`+1.
- Samples are taken at `sc`=M-1, M and M+1. The vote is the 2-of-3 majority and is resolved on the tick where `sc`=M+1.
- When `sc`=OVERSAMPLE-1, the next tick wraps `sc` to 0 and advances the state.
- START: if the vote is 1, it is a false start; go to IDLE immediately and produce no outputs. Otherwise stay in START until the wrap.
- DATA: the vote is shifted in from the MSB side of the shift register, so bit 0 is received first. A bit index counts 0..DATA_BITS-1; after the last bit, go to PARITY or STOP.
- PARITY: compute the XOR over the payload and the voted parity bit. `parity_err` = (xor ≠ `PARITY_ODD`).
- STOP: at the vote (`sc`=M+1), load `data`, pulse `valid`, set `frame_err` = !vote, then go to IDLE.
  - The FSM does not wait for the stop-cell end, so a start bit immediately following the stop bit is caught.
- A `tick` that arrives while `valid` is high is processed normally; `valid` never stalls the receiver.
- Reset mid-frame: the FSM returns to IDLE and `sc`, the bit index and the shift register clear. A partial frame is discarded with no `valid`.

## Timing
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, synchroniser flops=1.
- Input latency is 2 clk cycles from `rxd` to `rx_s`. Start-edge uncertainty is 1 tick plus 2 clk.
- `valid`, `frame_err`, `parity_err` and `data` are registered. They update in the clk cycle after the tick that resolves the STOP vote.
  - `valid`, `frame_err` and `parity_err` stay high for exactly 1 clk.
- Frame-end latency: `valid` rises about (1 + DATA_BITS [+1 parity])×OVERSAMPLE + M + 1 ticks after the start-edge tick.
- `busy` rises in the cycle after start detection. It falls in the same cycle that `valid` rises, or 1 clk after a false start.

## Configuration
- Macro `UART_RX_PARITY_EN`.
  - Defined: the PARITY state exists, one parity cell is expected between the data bits and the stop bit, and `parity_err` is driven as above.
  - Undefined: there is no PARITY state, the frame is 8N1-style (DATA_BITS + 1 stop), and `parity_err` is tied to 0. `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum;
  - the default OVERSAMPLE and DATA_BITS constants;
  - the `uart_majority3` function.
- The baud generator and transmitter use the same package.
- One sub-module, `uart_rx_sync`: a 2-flop synchroniser with a reset value of 1, reusable for other async pins (e.g. encoder inputs).

## Test plan
Bench drives `tick` every 4 clk with OVERSAMPLE=16, giving 64 clk per bit.
- Frame 0xA5 with stop=1 → one `valid` pulse, `data`=0xA5, `frame_err`=0, `busy` low after.
- `rxd` low for 3 ticks then high → no `valid`; `busy` drops by start-cell tick 9; a following 0x3C frame is received correctly.
- Frame 0x3C with stop bit driven 0 → `valid`=1, `data`=0x3C, `frame_err`=1.
- Frame 0x00 with `rxd` forced high for 1 tick at `sc`=8 of bit 2 → majority vote rejects the glitch, `data`=0x00.
- Assert `reset` during bit 4 of a frame → all outputs 0 the next cycle and no `valid`; the following frame 0x5A gives `data`=0x5A.
- With `UART_RX_PARITY_EN` and `PARITY_ODD`=0: 0x07 with parity bit 1 → `parity_err`=0; with parity bit 0 → `parity_err`=1.
  - Back-to-back frames 0x11 then 0x22 with no idle gap → two `valid` pulses carrying the correct data.
